// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: UART capture handshake plus the consumer read port.
interface uart_rx_fifo_if #(
  parameter int unsigned AW = 4
);
  localparam int unsigned CW = AW + 1;

  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          ready_clr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          ovr_clr;

  // Environment side: UART plus consumer
  modport master (
    output rx_ready, rx_data, rd_en, ovr_clr,
    input  ready_clr, rd_data, empty, full, count, overrun
  );

  // Buffer side
  modport slave (
    input  rx_ready, rx_data, rd_en, ovr_clr,
    output ready_clr, rd_data, empty, full, count, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each ready byte into a show-ahead FIFO,
// runs the ready_clr handshake, and records dropped bytes in a sticky flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic           clk_50m,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overrun_q;
  logic          push_try;
  logic          pop;
  logic          push;
  logic          drop;

  // Capture FSM state register
  always_ff @(posedge clk_50m) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture FSM next state; one push attempt per ready assertion
  always_comb begin
    state_d  = state_q;
    push_try = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_ready) begin
          push_try = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (!bus.rx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop needs a stored entry; a full FIFO still takes a byte if one leaves
  always_comb begin
    pop  = bus.rd_en && (count_q != '0);
    push = push_try && ((count_q < FULL_CNT) || pop);
    drop = push_try && !push;
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk_50m) begin
    if (!rst_n)           overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (bus.ovr_clr) overrun_q <= 1'b0;
  end

  // Outputs derived directly from registered state
  always_comb begin
    bus.ready_clr = (state_q == CLEAR);
    bus.rd_data   = (count_q != '0) ? mem[rd_ptr] : 8'h00;
    bus.empty     = (count_q == '0);
    bus.full      = (count_q == FULL_CNT);
    bus.count     = count_q;
    bus.overrun   = overrun_q;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the `uart` block. It watches the UART's `ready`/`data_out` pair and captures each received byte into a DEPTH-entry FIFO. It performs the `ready_clr` handshake back to the UART and presents the bytes to the consumer through a show-ahead read port. Overflow is never silent: a sticky overrun flag records any byte that arrives while the FIFO is full.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, 4: pointer width, log2(DEPTH).
- `clk_50m`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_ready`  in  1  UART `ready`; level, held high until cleared.
- `rx_data`  in  8  UART `data_out`; stable while `rx_ready`=1.
- `ready_clr`  out  1  to UART `ready_clr`; registered.
- `rd_en`  in  1  consumer pop request.
- `rd_data`  out  8  head-of-FIFO byte (show-ahead).
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overrun`  out  1  sticky; a received byte was dropped.
- `ovr_clr`  in  1  clears `overrun`.

## Operation
- Capture FSM, registered state:
  - IDLE: `ready_clr`=0. If `rx_ready`=1, attempt a push of `rx_data`, then go to CLEAR.
  - CLEAR: `ready_clr`=1. Stay until `rx_ready`=0, then go to IDLE.
  - Because CLEAR waits for `rx_ready` low, a byte is never captured twice, regardless of UART clear latency.
- Push attempt accept rule:
  - Accepted if `count`<DEPTH, or if a pop is accepted in the same cycle.
  - An accepted push writes `mem[wr_ptr]`; `wr_ptr` increments mod DEPTH.
  - Otherwise the byte is discarded and `overrun` is set. The CLEAR handshake still runs.
- Pop rule:
  - Accepted iff `rd_en`=1 and `count`>0; `rd_ptr` increments mod DEPTH.
  - `rd_en` while empty is ignored: no pointer or count change, no error flag.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Both, or neither: unchanged.
  - Pointers wrap naturally at DEPTH; `count` is the authoritative fill measure.
- Outputs:
  - `rd_data` = `mem[rd_ptr]` when `count`>0, else 8'h00.
  - `empty` = (`count`==0); `full` = (`count`==DEPTH).
- `overrun` collision rule: a set in the same cycle as `ovr_clr` wins, and `overrun` stays 1.
- Storage array is not reset; only pointers, count, FSM and flags are.

## Timing
- Reset values:
  - `ready_clr`=0, `rd_data`=8'h00, `empty`=1, `full`=0, `count`=0, `overrun`=0.
  - FSM=IDLE, pointers=0.
- Reset mid-handshake: FSM returns to IDLE and `ready_clr` drops.
  - If `rx_ready` is still 1 after reset releases, that byte is captured as new data.
- Capture latency, with `rx_ready` sampled 1 at edge N in IDLE:
  - Byte written at edge N.
  - `count`, `empty` and `rd_data` reflect it after edge N.
  - `ready_clr`=1 from edge N to the first edge at which `rx_ready`=0 is sampled.
- Minimum inter-byte spacing: IDLE → CLEAR → IDLE is 2 cycles with a 1-cycle UART clear. This is far below one UART frame, so no back-pressure is applied to the UART.
- Pop: `rd_data` shows the next entry after the edge where the pop is accepted. Zero-latency show-ahead; the consumer samples `rd_data` with `rd_en` in the same cycle.
- Push into empty and pop in the same cycle is impossible by rule: pop requires `count`>0 before the edge.
- Full with simultaneous push and pop: both accepted, `count` stays DEPTH, `overrun` unchanged.

## Test plan
- Single byte: `rx_ready`=1 with `rx_data`=8'hA5, model UART clears ready 1 cycle after `ready_clr` → `count`=1, `rd_data`=A5, `ready_clr` high exactly 2 cycles; `rd_en` pulse → `empty`=1, `rd_data`=00.
- Fill and overflow: 16 bytes 00..0F with no reads → `full`=1, `count`=16. 17th byte 10 → dropped, `overrun`=1, `ready_clr` handshake completes. Drain → 00..0F in order, then `empty`.
- Full with simultaneous pop: FIFO full (00..0F), byte 20 arrives on the same cycle as `rd_en` → `count`=16, `overrun`=0. Drain order is 01..0F, 20 (exercises pointer wrap).
- Pop on empty: `rd_en`=1 for 5 cycles on an empty FIFO → `count`=0, pointers unchanged, `overrun`=0. Then push 8'h3C → `rd_data`=3C.
- Slow UART clear and reset: UART holds `rx_ready` 4 cycles after `ready_clr` → exactly one push, `ready_clr` high until ready drops. Repeat with `rst_n`=0 asserted in CLEAR → all outputs at reset values next cycle; byte recaptured if `rx_ready` is still 1.
- Overrun clear collision: `ovr_clr`=1 on the same cycle as a dropped byte → `overrun` stays 1. `ovr_clr` on a later idle cycle → `overrun`=0.
